// File: rtl/bram_sync_dp.sv
// True dual-port synchronous BRAM with per-byte write enables and selectable read-during-write mode.
// Define BRAM_OUT_REG_EN to add a second output register stage per port (read latency 2).
module bram_sync_dp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int BYTE_WIDTH = 8,
  parameter int RD_MODE    = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             a_en,
  input  logic                             a_wr,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] a_be,
  input  logic [ADDR_WIDTH-1:0]            a_addr,
  input  logic [DATA_WIDTH-1:0]            a_data_in,
  output logic [DATA_WIDTH-1:0]            a_data_out,
  output logic                             a_valid,
  input  logic                             b_en,
  input  logic                             b_wr,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] b_be,
  input  logic [ADDR_WIDTH-1:0]            b_addr,
  input  logic [DATA_WIDTH-1:0]            b_data_in,
  output logic [DATA_WIDTH-1:0]            b_data_out,
  output logic                             b_valid
);
  localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  generate
    if ((DATA_WIDTH % BYTE_WIDTH) != 0 || RD_MODE > 2) begin : g_cfg_err
      initial begin
        $display("bram_sync_dp: bad config DATA_WIDTH=%0d BYTE_WIDTH=%0d RD_MODE=%0d",
                 DATA_WIDTH, BYTE_WIDTH, RD_MODE);
        $finish;
      end
    end
  endgenerate

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [1:0]                 en, wr, vld;
  logic [1:0][NB-1:0]         be;
  logic [1:0][ADDR_WIDTH-1:0] addr;
  logic [1:0][DATA_WIDTH-1:0] din, dout;

  assign en   = {b_en, a_en};
  assign wr   = {b_wr, a_wr};
  assign be   = {b_be, a_be};
  assign addr = {b_addr, a_addr};
  assign din  = {b_data_in, a_data_in};

  // Port B lanes are issued first so a same-address, same-lane A write lands last and wins.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NB; i++) begin
        if (b_en && b_wr && b_be[i])
          mem[b_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= b_data_in[i*BYTE_WIDTH +: BYTE_WIDTH];
        if (a_en && a_wr && a_be[i])
          mem[a_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= a_data_in[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [DATA_WIDTH-1:0] rd_word, merged, s1_data;
    logic                  s1_vld;

    // Pre-edge contents: gives READ_FIRST and old-data cross-port reads for free.
    assign rd_word = mem[addr[p]];

    always_comb begin
      merged = rd_word;
      for (int i = 0; i < NB; i++)
        if (be[p][i]) merged[i*BYTE_WIDTH +: BYTE_WIDTH] = din[p][i*BYTE_WIDTH +: BYTE_WIDTH];
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        s1_data <= '0;
        s1_vld  <= 1'b0;
      end else begin
        s1_vld <= 1'b0;
        if (en[p]) begin
          if (!wr[p] || RD_MODE == 0) begin
            s1_data <= rd_word;
            s1_vld  <= 1'b1;
          end else if (RD_MODE == 1) begin
            s1_data <= merged;
            s1_vld  <= 1'b1;
          end
        end
      end
    end

`ifdef BRAM_OUT_REG_EN
    logic [DATA_WIDTH-1:0] s2_data;
    logic                  s2_vld;

    always_ff @(posedge clk) begin
      if (rst) begin
        s2_data <= '0;
        s2_vld  <= 1'b0;
      end else begin
        s2_vld <= s1_vld;
        if (s1_vld) s2_data <= s1_data;
      end
    end

    assign dout[p] = s2_data;
    assign vld[p]  = s2_vld;
`else
    assign dout[p] = s1_data;
    assign vld[p]  = s1_vld;
`endif
  end

  assign a_data_out = dout[0];
  assign a_valid    = vld[0];
  assign b_data_out = dout[1];
  assign b_valid    = vld[1];
endmodule

// File: tb/tb_bram_sync_dp.sv
// Random + directed bench for bram_sync_dp: three DUTs (one per RD_MODE) share stimulus
// and are compared every cycle against a word-array reference model.
module tb_bram_sync_dp;
`ifdef BRAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        pen [2], pwr [2];
  logic [3:0]  pbe [2], paddr [2];
  logic [31:0] pdin [2];
  logic [31:0] dout [3][2];
  logic        vout [3][2];

  always #5 clk = ~clk;

  for (genvar m = 0; m < 3; m++) begin : g_dut
    bram_sync_dp #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .BYTE_WIDTH(8), .RD_MODE(m)) u_dut (
      .clk(clk), .rst(rst),
      .a_en(pen[0]), .a_wr(pwr[0]), .a_be(pbe[0]), .a_addr(paddr[0]), .a_data_in(pdin[0]),
      .a_data_out(dout[m][0]), .a_valid(vout[m][0]),
      .b_en(pen[1]), .b_wr(pwr[1]), .b_be(pbe[1]), .b_addr(paddr[1]), .b_data_in(pdin[1]),
      .b_data_out(dout[m][1]), .b_valid(vout[m][1])
    );
  end

  // reference model state
  logic [31:0] mem_m [16];
  logic [31:0] s1_d [3][2], s2_d [3][2];
  logic        s1_v [3][2], s2_v [3][2];
  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = nw[i*8 +: 8];
    return r;
  endfunction

  task automatic model_step();
    logic [31:0] old [16];
    old = mem_m;
    for (int m = 0; m < 3; m++)
      for (int p = 0; p < 2; p++) begin
        if (rst) begin
          s1_d[m][p] = 0; s1_v[m][p] = 0; s2_d[m][p] = 0; s2_v[m][p] = 0;
        end else begin
          s2_v[m][p] = s1_v[m][p];
          if (s1_v[m][p]) s2_d[m][p] = s1_d[m][p];
          s1_v[m][p] = 0;
          if (pen[p]) begin
            if (!pwr[p]) begin
              s1_d[m][p] = old[paddr[p]]; s1_v[m][p] = 1;
            end else if (m == 0) begin
              s1_d[m][p] = old[paddr[p]]; s1_v[m][p] = 1;
            end else if (m == 1) begin
              s1_d[m][p] = merge(old[paddr[p]], pdin[p], pbe[p]); s1_v[m][p] = 1;
            end
          end
        end
      end
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        logic aw, bw;
        aw = pen[0] && pwr[0] && pbe[0][i];
        bw = pen[1] && pwr[1] && pbe[1][i];
        if (aw) mem_m[paddr[0]][i*8 +: 8] = pdin[0][i*8 +: 8];
        if (bw && !(aw && paddr[0] == paddr[1])) mem_m[paddr[1]][i*8 +: 8] = pdin[1][i*8 +: 8];
      end
    end
  endtask

  task automatic step(input bit do_chk);
    @(posedge clk);
    model_step();
    #1;
    if (do_chk)
      for (int m = 0; m < 3; m++)
        for (int p = 0; p < 2; p++) begin
          chk($sformatf("m%0d_p%0d_data", m, p), dout[m][p], (LAT == 2) ? s2_d[m][p] : s1_d[m][p]);
          chk($sformatf("m%0d_p%0d_valid", m, p), {31'b0, vout[m][p]},
              {31'b0, (LAT == 2) ? s2_v[m][p] : s1_v[m][p]});
        end
  endtask

  task automatic idle();
    for (int p = 0; p < 2; p++) begin
      pen[p] = 0; pwr[p] = 0; pbe[p] = 0; paddr[p] = 0; pdin[p] = 0;
    end
  endtask

  task automatic port(input int p, input logic en, input logic w, input logic [3:0] be,
                      input logic [3:0] a, input logic [31:0] d);
    pen[p] = en; pwr[p] = w; pbe[p] = be; paddr[p] = a; pdin[p] = d;
  endtask

  task automatic settle();
    idle();
    for (int k = 1; k < LAT; k++) step(1);
  endtask

  initial begin
    rst = 1; idle();
    for (int m = 0; m < 3; m++)
      for (int p = 0; p < 2; p++) begin
        s1_d[m][p] = 0; s1_v[m][p] = 0; s2_d[m][p] = 0; s2_v[m][p] = 0;
      end
    step(0); step(1);
    // Give every word a known value, then reset to flush outputs that saw undefined data.
    rst = 0;
    for (int a = 0; a < 16; a++) begin
      port(0, 1, 1, 4'hF, a[3:0], $urandom); step(0);
    end
    idle(); rst = 1; step(1);
    for (int m = 0; m < 3; m++) chk("reset_data", dout[m][0], 32'h0);
    rst = 0;

    // basic write then read
    port(0, 1, 1, 4'hF, 4'd6, 32'hDEADBEEF); step(1);
    port(0, 1, 0, 4'h0, 4'd6, 32'h0); step(1); settle();
    chk("basic_data", dout[0][0], 32'hDEADBEEF);
    chk("basic_valid", {31'b0, vout[0][0]}, 32'h1);

    // byte lanes
    port(0, 1, 1, 4'hF, 4'd2, 32'h11223344); step(1);
    idle(); port(1, 1, 1, 4'b0101, 4'd2, 32'hAABBCCDD); step(1);
    idle(); port(0, 1, 0, 4'h0, 4'd2, 32'h0); step(1); settle();
    chk("byte_lanes", dout[0][0], 32'h11BB33DD);

    // read-during-write modes
    port(0, 1, 1, 4'hF, 4'd3, 32'h1); step(1);
    port(0, 1, 1, 4'hF, 4'd3, 32'h2); step(1); settle();
    chk("read_first", dout[0][0], 32'h1);
    chk("write_first", dout[1][0], 32'h2);
    chk("no_change_hold", dout[2][0], 32'h11BB33DD);
    chk("no_change_valid", {31'b0, vout[2][0]}, 32'h0);

    // collisions at addr 5
    port(0, 1, 1, 4'b1100, 4'd5, 32'hFFFF0000); port(1, 1, 1, 4'hF, 4'd5, 32'h12345678); step(1);
    idle(); port(0, 1, 0, 4'h0, 4'd5, 32'h0); step(1); settle();
    chk("ww_collision", dout[0][0], 32'hFFFF5678);
    port(0, 1, 1, 4'hF, 4'd5, 32'h0000CAFE); port(1, 1, 0, 4'h0, 4'd5, 32'h0); step(1); settle();
    for (int m = 0; m < 3; m++) chk("rw_collision", dout[m][1], 32'hFFFF5678);
    port(1, 1, 0, 4'h0, 4'd5, 32'h0); step(1); settle();
    chk("rw_after", dout[0][1], 32'h0000CAFE);

    // reset mid-operation
    rst = 1; port(0, 1, 0, 4'h0, 4'd6, 32'h0); step(1);
    chk("rst_read_data", dout[0][0], 32'h0);
    chk("rst_read_valid", {31'b0, vout[0][0]}, 32'h0);
    port(0, 1, 1, 4'hF, 4'd6, 32'h0); step(1);
    rst = 0; port(0, 1, 0, 4'h0, 4'd6, 32'h0); step(1); settle();
    chk("rst_write_blocked", dout[0][0], 32'hDEADBEEF);

    // back-to-back streaming reads
    port(0, 1, 0, 4'h0, 4'd6, 32'h0); step(1);
    port(0, 1, 0, 4'h0, 4'd2, 32'h0); step(1);
    idle(); step(1);

    // random traffic, narrow address range to provoke collisions
    for (int c = 0; c < 2000; c++) begin
      rst = ($urandom_range(0, 49) == 0);
      for (int p = 0; p < 2; p++)
        port(p, $urandom_range(0, 3) != 0, $urandom_range(0, 1), 4'($urandom),
             4'($urandom_range(0, 7)), $urandom);
      step(1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
